inst_fetch: RTL and testbench

Instruction-fetch stage between the program counter register and the decode stage. Takes the PC, issues reads to a synchronous instruction ROM, and queues each returned {pc, instruction} pair in a small buffer. Presents the pairs to decode through a valid/ready handshake. Back-pressures the PC register and discards stale fetches on a pipeline flush.

---
 rtl/inst_fetch_pkg.sv | 10 +
 rtl/fetch_buf.sv | 72 +++++++
 rtl/inst_fetch.sv | 88 ++++++++
 tb/tb_inst_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage and its buffer.
package cpu_defs;

   localparam int INST_W = 32;
   localparam int AW_DEF = 32;

   // Instruction shown to decode while no buffer entry is valid.
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding {pc, instruction} pairs for the fetch stage.
// Reset clears pointers, count and storage; clear empties the FIFO only.
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [W-1:0]               head_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_eff;
   logic          push_eff;

   // An empty FIFO ignores pops; a full one accepts a push only alongside a pop.
   assign pop_eff  = pop_i && (count_q != '0);
   assign push_eff = push_i && ((count_q != CW'(DEPTH)) || pop_eff);

   // Next-state pointers and occupancy; clear overrides push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_eff) - CW'(pop_eff);
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; a push during clear is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_eff && !clear_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues ROM reads for the incoming PC, queues the
// returned {pc, instruction} pairs and hands them to decode with valid/ready.
module inst_fetch
   import cpu_defs::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     pc,
   input  logic              pc_ce,
   output logic              pc_ready,
   output logic              imem_ce,
   output logic [AW-1:0]     imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              flush,
   output logic              id_valid,
   output logic [AW-1:0]     id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              id_ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = AW + INST_W;

   logic [CW-1:0] count;
   logic [EW-1:0] head;
   logic [CW:0]   occ;
   logic          clear;
   logic          pop;
   logic          push;
   logic          issue;
   logic          inflight_q, inflight_d;
   logic [AW-1:0] pc_q, pc_d;

   assign clear    = rst || flush;
   assign id_valid = (count != '0);
   assign pop      = id_valid && id_ready;

   // Slots committed after this edge: held entries plus the read already in
   // flight, less the one decode takes now. Issue only if one remains free,
   // so the ROM response always has room when it lands.
   assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue = pc_ce && !flush && !rst && (occ < (CW+1)'(DEPTH));

   assign pc_ready  = issue;
   assign imem_ce   = issue;
   assign imem_addr = {pc[AW-1:2], 2'b00};

   // The ROM answers one cycle after issue; a flush in that cycle drops it.
   assign push = inflight_q && !clear;

   // Track the outstanding read and the full PC it was issued for.
   always_comb begin
      inflight_d = issue;
      pc_d       = issue ? pc : pc_q;
   end

   // Fetch tracking registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         pc_q       <= '0;
      end else begin
         inflight_q <= inflight_d;
         pc_q       <= pc_d;
      end
   end

   fetch_buf #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .push_i  (push),
      .wdata_i ({pc_q, imem_rdata}),
      .pop_i   (pop),
      .count_o (count),
      .head_o  (head)
   );

   assign id_pc   = head[EW-1:INST_W];
   assign id_inst = id_valid ? head[INST_W-1:0] : NOP_INST;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch (DEPTH=2, AW=32) with a one-cycle ROM model.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        pc_ce;
   logic        pc_ready;
   logic        imem_ce;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;

   int n_asserts = 0;
   int n_fail    = 0;

   inst_fetch #(.DEPTH(2), .AW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_ce      (pc_ce),
      .pc_ready   (pc_ready),
      .imem_ce    (imem_ce),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_ready   (id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: word at addr holds 0x1000_0000 + addr.
   initial imem_rdata = 32'h0;
   always @(posedge clk) begin
      if (imem_ce) imem_rdata <= 32'h1000_0000 + imem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic ce, input logic [31:0] p,
                        input logic rdy, input logic fl);
      rst = r; pc_ce = ce; pc = p; id_ready = rdy; flush = fl;
      #1;
   endtask

   initial begin
      rst = 1'b1; pc_ce = 1'b0; pc = 32'h0; id_ready = 1'b0; flush = 1'b0;

      // Reset held for three cycles
      cyc();
      drive(1, 0, 32'h0, 0, 0);
      cyc();
      drive(1, 0, 32'h0, 0, 0);
      cyc();
      drive(1, 1, 32'h0, 1, 0);
      chk("rst_pc_ready", {31'h0, pc_ready}, 32'd0);
      chk("rst_imem_ce",  {31'h0, imem_ce},  32'd0);
      chk("rst_id_valid", {31'h0, id_valid}, 32'd0);
      chk("rst_id_pc",    id_pc,             32'h0);
      chk("rst_id_inst",  id_inst,           32'h0);
      cyc();

      // c0: first fetch
      drive(0, 1, 32'h0, 1, 0);
      chk("c0_pc_ready", {31'h0, pc_ready}, 32'd1);
      chk("c0_imem_addr", imem_addr, 32'h0);
      chk("c0_id_valid", {31'h0, id_valid}, 32'd0);
      cyc();
      // c1: no bypass, still empty
      drive(0, 1, 32'h4, 1, 0);
      chk("c1_id_valid", {31'h0, id_valid}, 32'd0);
      chk("c1_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();
      // c2: first entry two cycles after first accept
      drive(0, 1, 32'h8, 1, 0);
      chk("c2_id_valid", {31'h0, id_valid}, 32'd1);
      chk("c2_id_pc",   id_pc,   32'h0);
      chk("c2_id_inst", id_inst, 32'h1000_0000);
      chk("c2_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();
      // c3
      drive(0, 1, 32'hC, 1, 0);
      chk("c3_id_pc",   id_pc,   32'h4);
      chk("c3_id_inst", id_inst, 32'h1000_0004);
      chk("c3_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();

      // c4..c8: decode stall for five cycles
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 32'h10, 0, 0);
         chk("stall_pc_ready", {31'h0, pc_ready}, 32'd0);
         chk("stall_id_valid", {31'h0, id_valid}, 32'd1);
         chk("stall_id_pc",   id_pc,   32'h8);
         chk("stall_id_inst", id_inst, 32'h1000_0008);
         cyc();
      end

      // c9: ready returns, pc_ready reasserts in the same cycle
      drive(0, 1, 32'h10, 1, 0);
      chk("c9_pc_ready", {31'h0, pc_ready}, 32'd1);
      chk("c9_id_pc", id_pc, 32'h8);
      cyc();
      // c10..c11: resume without gaps
      drive(0, 1, 32'h14, 1, 0);
      chk("c10_id_pc", id_pc, 32'hC);
      chk("c10_id_inst", id_inst, 32'h1000_000C);
      chk("c10_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();
      drive(0, 1, 32'h18, 1, 0);
      chk("c11_id_pc", id_pc, 32'h10);
      chk("c11_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();
      // c12: stall one cycle to fill buffer
      drive(0, 1, 32'h1C, 0, 0);
      chk("c12_id_pc", id_pc, 32'h14);
      chk("c12_pc_ready", {31'h0, pc_ready}, 32'd0);
      cyc();
      // c13: pop 0x14, issue 0x1C -> one entry plus one in flight
      drive(0, 1, 32'h1C, 1, 0);
      chk("c13_id_pc", id_pc, 32'h14);
      chk("c13_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();

      // c14: flush together with id_ready
      drive(0, 1, 32'h20, 1, 1);
      chk("flush_imem_ce", {31'h0, imem_ce}, 32'd0);
      chk("flush_pc_ready", {31'h0, pc_ready}, 32'd0);
      cyc();
      // c15: buffer empty after flush
      drive(0, 1, 32'h20, 1, 0);
      chk("post_flush_id_valid", {31'h0, id_valid}, 32'd0);
      chk("post_flush_pc_ready", {31'h0, pc_ready}, 32'd1);
      chk("post_flush_imem_addr", imem_addr, 32'h20);
      cyc();
      // c16: dropped response must not appear
      drive(0, 1, 32'h24, 1, 0);
      chk("c16_id_valid", {31'h0, id_valid}, 32'd0);
      cyc();
      // c17: first PC accepted after flush is delivered next
      drive(0, 1, 32'h28, 1, 0);
      chk("c17_id_valid", {31'h0, id_valid}, 32'd1);
      chk("c17_id_pc", id_pc, 32'h20);
      chk("c17_id_inst", id_inst, 32'h1000_0020);
      cyc();

      // c18: misaligned PC
      drive(0, 1, 32'h6, 1, 0);
      chk("mis_imem_addr", imem_addr, 32'h4);
      chk("mis_pc_ready", {31'h0, pc_ready}, 32'd1);
      chk("c18_id_pc", id_pc, 32'h24);
      cyc();
      drive(0, 0, 32'h0, 1, 0);
      chk("c19_id_pc", id_pc, 32'h28);
      chk("c19_pc_ready", {31'h0, pc_ready}, 32'd0);
      cyc();
      drive(0, 0, 32'h0, 1, 0);
      chk("mis_id_pc", id_pc, 32'h6);
      chk("mis_id_inst", id_inst, 32'h1000_0004);
      cyc();
      // c21: drained, issue one fetch
      drive(0, 1, 32'h100, 1, 0);
      chk("c21_id_valid", {31'h0, id_valid}, 32'd0);
      chk("c21_pc_ready", {31'h0, pc_ready}, 32'd1);
      cyc();
      // c22: reset one cycle after the issue
      drive(1, 1, 32'h104, 1, 0);
      chk("rst2_pc_ready", {31'h0, pc_ready}, 32'd0);
      chk("rst2_imem_ce", {31'h0, imem_ce}, 32'd0);
      cyc();
      drive(0, 0, 32'h0, 1, 0);
      chk("rst2_id_valid_a", {31'h0, id_valid}, 32'd0);
      chk("rst2_id_pc", id_pc, 32'h0);
      chk("rst2_id_inst", id_inst, 32'h0);
      cyc();
      drive(0, 0, 32'h0, 1, 0);
      chk("rst2_id_valid_b", {31'h0, id_valid}, 32'd0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
